// File: rtl/ws2812_pkg.sv
// ws2812_pkg: timing constants and pixel format shared by the WS2812 LED
// driver and the WS2812 receive decoder (all cycle counts at 50 MHz).
package ws2812_pkg;

  localparam int unsigned PIXEL_W        = 24;
  localparam int unsigned T0H_CYC        = 20;
  localparam int unsigned T1H_CYC        = 40;
  localparam int unsigned TBIT_CYC       = 62;
  localparam int unsigned RESET_CYC      = 2500;

  // Receiver decision thresholds
  localparam int unsigned MIN_HIGH_DEF   = 8;
  localparam int unsigned BIT_THRESH_DEF = 30;
  localparam int unsigned MAX_HIGH_DEF   = 60;

  // One pixel as it travels on the wire: green first, MSB first
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_pixel_t;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_HIGH = 2'd1,
    RX_LOW  = 2'd2
  } rx_state_e;

  // 8-bit increment that sticks at 255
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for asynchronous inputs.
// Ports:
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset, clears both stages
//   d_i    - asynchronous input
//   q_o    - synchronized output (2 clk latency)
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First stage may go metastable; second stage gives it a cycle to settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ws2812_rx_decoder.sv
// ws2812_rx_decoder: decodes a WS2812 pulse-width-coded line into 24-bit
// GRB pixel words and frame-end (latch) events.
// Optional build macro: WS2812_FORWARD_EN -- consume the first pixel of each
// frame and relay the rest of the frame on dout (WS2812 cascade behaviour).
// Without it dout is tied low.
// Ports:
//   clk          - system clock (50 MHz)
//   rst_n        - asynchronous active-low reset
//   din          - WS2812 serial line, asynchronous, idles low
//   pixel_data   - last complete pixel, GRB, G[7] received first
//   pixel_valid  - 1-cycle pulse, pixel_data updated
//   pixel_count  - pixels decoded in current/last frame, saturates at 255
//   frame_end    - 1-cycle pulse when the latch gap is detected
//   error        - 1-cycle pulse: glitch, over-long high, or partial pixel
//   dout         - cascade output
module ws2812_rx_decoder
  import ws2812_pkg::*;
#(
  parameter int unsigned MIN_HIGH     = MIN_HIGH_DEF,
  parameter int unsigned BIT_THRESH   = BIT_THRESH_DEF,
  parameter int unsigned MAX_HIGH     = MAX_HIGH_DEF,
  parameter int unsigned RESET_CYCLES = RESET_CYC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din,
  output logic [PIXEL_W-1:0] pixel_data,
  output logic               pixel_valid,
  output logic [7:0]         pixel_count,
  output logic               frame_end,
  output logic               error,
  output logic               dout
);

  localparam int unsigned HCNT_W   = $clog2(MAX_HIGH + 2);
  localparam int unsigned LCNT_W   = $clog2(RESET_CYCLES + 1);
  localparam int unsigned BITCNT_W = $clog2(PIXEL_W);
  localparam int unsigned SHREG_W  = PIXEL_W - 1;

  localparam logic [HCNT_W-1:0]   MIN_HIGH_C   = HCNT_W'(MIN_HIGH);
  localparam logic [HCNT_W-1:0]   BIT_THRESH_C = HCNT_W'(BIT_THRESH);
  localparam logic [HCNT_W-1:0]   MAX_HIGH_C   = HCNT_W'(MAX_HIGH);
  localparam logic [HCNT_W-1:0]   HSAT_C       = HCNT_W'(MAX_HIGH + 1);
  localparam logic [LCNT_W-1:0]   RESET_C      = LCNT_W'(RESET_CYCLES);
  localparam logic [BITCNT_W-1:0] LAST_BIT_C   = BITCNT_W'(PIXEL_W - 1);

  logic din_s;
  logic din_prev_q;
  logic rise_c;
  logic fall_c;
  logic bit_c;

  rx_state_e             state_q, state_d;
  logic [HCNT_W-1:0]     hcnt_q, hcnt_d;
  logic [LCNT_W-1:0]     lcnt_q, lcnt_d;
  logic [SHREG_W-1:0]    shreg_q, shreg_d;
  logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
  grb_pixel_t            pixel_data_q, pixel_data_d;
  logic [7:0]            pixel_count_q, pixel_count_d;
  logic                  pixel_valid_q, pixel_valid_d;
  logic                  frame_end_q, frame_end_d;
  logic                  error_q, error_d;
`ifdef WS2812_FORWARD_EN
  logic                  fwd_q, fwd_d;
  logic                  dout_q;
`endif

  // Bring the asynchronous line into the clk domain
  sync_2ff #(.WIDTH(1)) u_sync_din (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (din),
    .q_o   (din_s)
  );

  assign rise_c = din_s & ~din_prev_q;
  assign fall_c = ~din_s & din_prev_q;
  assign bit_c  = (hcnt_q >= BIT_THRESH_C);

  // Next-state and output decode
  always_comb begin
    state_d       = state_q;
    hcnt_d        = hcnt_q;
    lcnt_d        = lcnt_q;
    shreg_d       = shreg_q;
    bitcnt_d      = bitcnt_q;
    pixel_data_d  = pixel_data_q;
    pixel_count_d = pixel_count_q;
    pixel_valid_d = 1'b0;
    frame_end_d   = 1'b0;
    error_d       = 1'b0;
`ifdef WS2812_FORWARD_EN
    fwd_d         = fwd_q;
`endif

    unique case (state_q)
      RX_IDLE: begin
        // First rise after a latch gap starts a new frame
        if (rise_c) begin
          state_d       = RX_HIGH;
          hcnt_d        = HCNT_W'(1);
          pixel_count_d = 8'd0;
        end
      end

      RX_HIGH: begin
        if (fall_c) begin
          state_d = RX_LOW;
          lcnt_d  = LCNT_W'(1);
          if (hcnt_q < MIN_HIGH_C) begin
            error_d = 1'b1;
          end else begin
            // Over-long pulse still decodes as a 1, but is flagged
            if (hcnt_q > MAX_HIGH_C) begin
              error_d = 1'b1;
            end
            if (bitcnt_q == LAST_BIT_C) begin
              pixel_data_d  = grb_pixel_t'({shreg_q, bit_c});
              pixel_valid_d = 1'b1;
              bitcnt_d      = '0;
              pixel_count_d = sat_inc8(pixel_count_q);
`ifdef WS2812_FORWARD_EN
              // Line is low here, so enabling the relay never clips a pulse
              if (pixel_count_q == 8'd0) begin
                fwd_d = 1'b1;
              end
`endif
            end else begin
              shreg_d  = {shreg_q[SHREG_W-2:0], bit_c};
              bitcnt_d = bitcnt_q + BITCNT_W'(1);
            end
          end
        end else if (hcnt_q != HSAT_C) begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end

      RX_LOW: begin
        if (rise_c) begin
          state_d = RX_HIGH;
          hcnt_d  = HCNT_W'(1);
          lcnt_d  = '0;
        end else begin
          lcnt_d = lcnt_q + LCNT_W'(1);
          if (lcnt_d == RESET_C) begin
            frame_end_d = 1'b1;
            error_d     = (bitcnt_q != '0);
            bitcnt_d    = '0;
            lcnt_d      = '0;
            state_d     = RX_IDLE;
`ifdef WS2812_FORWARD_EN
            fwd_d       = 1'b0;
`endif
          end
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RX_IDLE;
      din_prev_q    <= 1'b0;
      hcnt_q        <= '0;
      lcnt_q        <= '0;
      shreg_q       <= '0;
      bitcnt_q      <= '0;
      pixel_data_q  <= '0;
      pixel_count_q <= '0;
      pixel_valid_q <= 1'b0;
      frame_end_q   <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      din_prev_q    <= din_s;
      hcnt_q        <= hcnt_d;
      lcnt_q        <= lcnt_d;
      shreg_q       <= shreg_d;
      bitcnt_q      <= bitcnt_d;
      pixel_data_q  <= pixel_data_d;
      pixel_count_q <= pixel_count_d;
      pixel_valid_q <= pixel_valid_d;
      frame_end_q   <= frame_end_d;
      error_q       <= error_d;
    end
  end

`ifdef WS2812_FORWARD_EN
  // Relay the synchronized line once the frame's first pixel is consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q  <= 1'b0;
      dout_q <= 1'b0;
    end else begin
      fwd_q  <= fwd_d;
      dout_q <= din_s & fwd_q;
    end
  end

  assign dout = dout_q;
`else
  assign dout = 1'b0;
`endif

  assign pixel_data  = pixel_data_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_count = pixel_count_q;
  assign frame_end   = frame_end_q;
  assign error       = error_q;

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// tb_ws2812_rx_decoder: directed bench for ws2812_rx_decoder. Drives WS2812
// bit patterns on din and checks decoded pixels, frame ends, errors and the
// cascade output (build with WS2812_FORWARD_EN to exercise forwarding).
module tb_ws2812_rx_decoder;

  logic        clk;
  logic        rst_n;
  logic        din;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [7:0]  pixel_count;
  logic        frame_end;
  logic        error;
  logic        dout;

  int checks = 0;
  int errors = 0;

  ws2812_rx_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_count (pixel_count),
    .frame_end   (frame_end),
    .error       (error),
    .dout        (dout)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Cycle counter and event recorder (sampled on the inactive edge)
  int          cyc = 0;
  int          pv_total = 0;
  int          pv_cyc = 0;
  logic [23:0] pv_data [0:63];
  int          fe_total = 0;
  int          fe_cyc = 0;
  int          err_total = 0;
  int          both_total = 0;
  int          dout_hi_total = 0;
  int          run = 0;
  int          dw [0:255];
  int          dw_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pixel_valid) begin
      pv_data[pv_total % 64] <= pixel_data;
      pv_total <= pv_total + 1;
      pv_cyc   <= cyc;
    end
    if (frame_end) begin
      fe_total <= fe_total + 1;
      fe_cyc   <= cyc;
    end
    if (error) err_total <= err_total + 1;
    if (frame_end && error) both_total <= both_total + 1;
    if (dout) begin
      dout_hi_total <= dout_hi_total + 1;
      run <= run + 1;
    end else if (run != 0) begin
      dw[dw_total % 256] <= run;
      dw_total <= dw_total + 1;
      run <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int last_fall_cyc = 0;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pulse(input int hi, input int lo);
    din = 1'b1;
    repeat (hi) @(negedge clk);
    din = 1'b0;
    last_fall_cyc = cyc;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (b) send_pulse(40, 22);
    else   send_pulse(20, 42);
  endtask

  task automatic send_bits(input logic [23:0] px, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(px[i]);
  endtask

  int b_pv, b_fe, b_err, b_both, b_dout, b_dw, t_fall, d, wbad, w, ew;

  initial begin
    din   = 1'b0;
    rst_n = 1'b0;
    idle(3);
    check("rst_pixel_data",  32'(pixel_data),  32'h0);
    check("rst_pixel_valid", 32'(pixel_valid), 32'h0);
    check("rst_pixel_count", 32'(pixel_count), 32'h0);
    check("rst_frame_end",   32'(frame_end),   32'h0);
    check("rst_error",       32'(error),       32'h0);
    check("rst_dout",        32'(dout),        32'h0);
    rst_n = 1'b1;
    idle(4);

    // Single pixel 00FF00 followed by a latch gap
    b_pv = pv_total; b_fe = fe_total; b_err = err_total;
    send_bits(24'h00FF00, 23, 0);
    t_fall = last_fall_cyc;
    idle(2600);
    check("t1_pv_count",   32'(pv_total - b_pv), 32'd1);
    check("t1_pixel_data", 32'(pv_data[b_pv % 64]), 32'h00FF00);
    check("t1_pv_latency", 32'(pv_cyc - t_fall), 32'd3);
    check("t1_pixel_count", 32'(pixel_count), 32'd1);
    check("t1_fe_count",   32'(fe_total - b_fe), 32'd1);
    d = fe_cyc - t_fall;
    check("t1_fe_delay_in_2500_2503", 32'((d >= 2500) && (d <= 2503)), 32'd1);
    check("t1_err_count",  32'(err_total - b_err), 32'd0);

    // Three pixels back-to-back
    b_pv = pv_total; b_err = err_total;
    send_bits(24'hFF0000, 23, 0);
    send_bits(24'h0000FF, 23, 0);
    send_bits(24'hA5A5A5, 23, 0);
    idle(2600);
    check("t2_pv_count",  32'(pv_total - b_pv), 32'd3);
    check("t2_pixel0",    32'(pv_data[(b_pv + 0) % 64]), 32'hFF0000);
    check("t2_pixel1",    32'(pv_data[(b_pv + 1) % 64]), 32'h0000FF);
    check("t2_pixel2",    32'(pv_data[(b_pv + 2) % 64]), 32'hA5A5A5);
    check("t2_pixel_count", 32'(pixel_count), 32'd3);
    check("t2_err_count", 32'(err_total - b_err), 32'd0);
    // First bit of the next frame clears the pixel count
    send_bits(24'h5A5A5A, 23, 23);
    check("t2_count_cleared", 32'(pixel_count), 32'd0);
    send_bits(24'h5A5A5A, 22, 0);
    idle(2600);
    check("t2_count_next",  32'(pixel_count), 32'd1);
    check("t2_next_pixel",  32'(pixel_data), 32'h5A5A5A);

    // Glitch between bits: flagged, ignored by the decoder
    b_pv = pv_total; b_err = err_total; b_fe = fe_total;
    send_bits(24'h3C96E1, 23, 12);
    send_pulse(5, 57);
    send_bits(24'h3C96E1, 11, 0);
    idle(2600);
    check("t3_err_count", 32'(err_total - b_err), 32'd1);
    check("t3_pv_count",  32'(pv_total - b_pv), 32'd1);
    check("t3_pixel",     32'(pv_data[b_pv % 64]), 32'h3C96E1);
    check("t3_fe_count",  32'(fe_total - b_fe), 32'd1);

    // Partial pixel at frame end
    b_pv = pv_total; b_err = err_total; b_fe = fe_total; b_both = both_total;
    send_bits(24'hC3C3C3, 23, 12);
    idle(2600);
    check("t4_pv_count",   32'(pv_total - b_pv), 32'd0);
    check("t4_fe_count",   32'(fe_total - b_fe), 32'd1);
    check("t4_err_count",  32'(err_total - b_err), 32'd1);
    check("t4_fe_err_same_cycle", 32'(both_total - b_both), 32'd1);
    b_pv = pv_total; b_err = err_total;
    send_bits(24'h0F0F0F, 23, 0);
    idle(2600);
    check("t4_clean_pv",    32'(pv_total - b_pv), 32'd1);
    check("t4_clean_pixel", 32'(pv_data[b_pv % 64]), 32'h0F0F0F);
    check("t4_clean_err",   32'(err_total - b_err), 32'd0);

    // Asynchronous reset in the middle of bit 10
    send_bits(24'hABCDEF, 23, 14);
    din = 1'b1;
    idle(10);
    rst_n = 1'b0;
    #1;
    check("t5_async_pixel_data",  32'(pixel_data),  32'h0);
    check("t5_async_pixel_count", 32'(pixel_count), 32'h0);
    check("t5_async_pixel_valid", 32'(pixel_valid), 32'h0);
    check("t5_async_error",       32'(error),       32'h0);
    @(negedge clk);
    din = 1'b0;
    idle(4);
    rst_n = 1'b1;
    idle(4);
    b_pv = pv_total; b_err = err_total;
    send_bits(24'h123456, 23, 0);
    idle(2600);
    check("t5_pv_count",    32'(pv_total - b_pv), 32'd1);
    check("t5_pixel",       32'(pv_data[b_pv % 64]), 32'h123456);
    check("t5_pixel_count", 32'(pixel_count), 32'd1);
    check("t5_err_count",   32'(err_total - b_err), 32'd0);

    // Cascade: first pixel consumed, second relayed
    b_pv = pv_total; b_dout = dout_hi_total; b_dw = dw_total;
    send_bits(24'h00FF00, 23, 0);
    send_bits(24'hFF0000, 23, 0);
    idle(2600);
    check("t6_pv_count", 32'(pv_total - b_pv), 32'd2);
    check("t6_pixel1",   32'(pv_data[(b_pv + 1) % 64]), 32'hFF0000);
`ifdef WS2812_FORWARD_EN
    check("t6_dout_pulses", 32'(dw_total - b_dw), 32'd24);
    wbad = 0;
    for (int k = 0; k < 24; k++) begin
      w  = dw[(b_dw + k) % 256];
      ew = (k < 8) ? 40 : 20;
      if ((w < ew - 1) || (w > ew + 1)) wbad++;
    end
    check("t6_dout_width_mismatches", 32'(wbad), 32'd0);
`else
    check("t6_dout_silent", 32'(dout_hi_total - b_dout), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
